serial_cmd_engine: RTL and testbench
====================================

SERIAL_CMD_ENGINE -- requirements
Module: serial_cmd_engine

Interface
REQ-001 The block SHALL have a parameter VERSION, default 21: firmware version byte returned by opcode 0x00.
REQ-002 The block SHALL have a parameter NREG, default 16, range 1..256: number of 8-bit configuration registers.
REQ-003 The block SHALL have a parameter NHIST, default 72, range 1..1024: number of 32-bit histogram words.
REQ-004 The block SHALL have a parameter TIMEOUT, default 1000000: inter-byte argument timeout in clk cycles.
REQ-005 The block SHALL have a parameter REG_INIT, default all zero, width NREG*8: reset and restore image, register i at bits [8i+7:8i].
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 rx_ready  input  1  one-cycle strobe indicating a valid rx_data byte.
REQ-009 rx_data  input  8  received byte.
REQ-010 tx_busy  input  1  UART transmitter busy; goes high the cycle after tx_start.
REQ-011 tx_start  output  1  one-cycle pulse that launches tx_data.
REQ-012 tx_data  output  8  byte to transmit.
REQ-013 hist_data  input  NHIST*32  histogram words, word i at [32i+31:32i].
REQ-014 hist_reset  output  1  one-cycle pulse that clears the external histograms.
REQ-015 cfg_regs  output  NREG*8  configuration register file.
REQ-016 cfg_update  output  1  one-cycle pulse on any cfg_regs change.
REQ-017 cfg_addr  output  8  address of the last written register; 0xFF after a restore.
REQ-018 err_count  output  8  saturating protocol error counter.

Function
REQ-019 States: IDLE, ARGS, EXEC, TX_LOAD, TX_WAIT; outside IDLE/ARGS, an rx_ready byte is dropped silently.
REQ-020 IDLE, rx_ready: latch opcode; go to ARGS if the opcode needs arguments (0x01:2, 0x02:1, 0x03:2), else to EXEC.
REQ-021 ARGS: store each byte, reset the timeout counter; after the last argument go to EXEC.
REQ-022 ARGS, timeout counter reaching TIMEOUT: go to IDLE, increment err_count, no register change.
REQ-023 0x00: send 1 byte = VERSION.
REQ-024 0x01 (addr, val): reg[addr] := val; pulse cfg_update; cfg_addr := addr; no response.
REQ-025 0x02 (addr): send 1 byte = reg[addr].
REQ-026 0x03 (addr, mask): reg[addr] := reg[addr] XOR mask; pulse cfg_update; cfg_addr := addr; no response.
REQ-027 0x0A: snapshot hist_data in EXEC; pulse hist_reset in the same cycle; send NHIST*4 bytes from the snapshot, word 0 first, each word little-endian.
REQ-028 0x0D: cfg_regs := REG_INIT; pulse cfg_update; cfg_addr := 0xFF; no response.
REQ-029 Any other opcode: increment err_count; return to IDLE.
REQ-030 addr >= NREG: writes and toggles are ignored (no cfg_update); a read returns 0x00; err_count increments.
REQ-031 err_count saturates at 255 and never wraps.
REQ-032 Latency: a register change is visible and cfg_update is high in the cycle after the edge that samples the final command byte.
REQ-033 TX_LOAD with tx_busy low: drive tx_data and pulse tx_start, then go to TX_WAIT; with tx_busy high, hold.
REQ-034 TX_WAIT: hold for one cycle; then go to TX_LOAD for the next byte, or to IDLE after the last byte.
REQ-035 The byte index SHALL be wide enough for NHIST*4+1 without wrap.

Reset
REQ-036 While rst_n is low: state IDLE; cfg_regs = REG_INIT; tx_start, hist_reset, cfg_update = 0; tx_data = 0; cfg_addr = 0; err_count = 0; counters and snapshot cleared.
REQ-037 A reset asserted mid-command or mid-transmission aborts the operation with no further tx_start.

Configuration
REQ-038 With CMD_CHECKSUM_EN defined: every response appends one byte equal to the XOR of all preceding response bytes (response length +1).
REQ-039 Without CMD_CHECKSUM_EN: responses contain exactly the payload bytes.

Verification
REQ-040 Opcode 0x00 -> single byte 0x15 (plus checksum byte 0x15 when CMD_CHECKSUM_EN is defined).
REQ-041 0x01,0x03,0xA5 then 0x02,0x03 -> cfg_update pulse with cfg_addr=3, then read returns 0xA5; 0x03,0x03,0x0F -> reg3=0xAA.
REQ-042 NHIST=2, hist word0=0x04030201, word1=0x08070605, opcode 0x0A -> hist_reset pulse, bytes 01..08; with checksum the 9th byte is 0x08.
REQ-043 0x01,0x05 then silence for TIMEOUT cycles -> return to IDLE, err_count=1, no cfg_update; unknown opcode 0x7E -> err_count=2.
REQ-044 rst_n low during a histogram dump -> tx_start stays low, cfg_regs=REG_INIT; after release, 0x00 is answered normally.

Source files
------------

// File: rtl/serial_cmd_engine_if.sv
// serial_cmd_engine_if
//   Byte-stream link between a UART core and the command engine.
//   Signals:
//     rx_ready  UART -> engine  one-cycle strobe, rx_data valid in that cycle
//     rx_data   UART -> engine  received byte
//     tx_busy   UART -> engine  transmitter busy, rises the cycle after tx_start
//     tx_start  engine -> UART  one-cycle launch pulse for tx_data
//     tx_data   engine -> UART  byte to transmit, held stable after tx_start
//   Handshake: receive is strobe-only (no back-pressure; a byte that arrives
//   while the engine is not listening is lost). Transmit: tx_start is only
//   raised in a cycle where tx_busy is low, and a byte counts as accepted on
//   the cycle tx_start is high.
//   Modports: master = UART side, slave = engine side.
interface serial_cmd_engine_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    output rx_ready, rx_data, tx_busy,
    input  tx_start, tx_data
  );

  modport slave (
    input  rx_ready, rx_data, tx_busy,
    output tx_start, tx_data
  );
endinterface

// File: rtl/serial_cmd_engine.sv
// serial_cmd_engine
//   Byte-oriented command interpreter: decodes opcodes and arguments arriving
//   from a UART, maintains an 8-bit configuration register file, reads and
//   snapshots histogram words, and streams responses back byte by byte.
//   Opcodes: 0x00 version, 0x01 write, 0x02 read, 0x03 toggle (xor),
//            0x0A histogram dump + clear, 0x0D restore REG_INIT.
//   Optional feature macro: CMD_CHECKSUM_EN appends an XOR checksum byte to
//   every response.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     uart        serial_cmd_engine_if.slave (rx_ready/rx_data/tx_busy in,
//                 tx_start/tx_data out)
//     hist_data   NHIST 32-bit histogram words, word i at [32i+31:32i]
//     hist_reset  one-cycle clear pulse for the external histograms
//     cfg_regs    NREG 8-bit registers, register i at [8i+7:8i]
//     cfg_update  one-cycle pulse on any cfg_regs change
//     cfg_addr    last written register address, 0xFF after a restore
//     err_count   saturating protocol error counter
//     dbg_state   current FSM state (IDLE=0, ARGS=1, EXEC=2, TX_LOAD=3, TX_WAIT=4)
module serial_cmd_engine #(
  parameter int              VERSION  = 21,
  parameter int              NREG     = 16,
  parameter int              NHIST    = 72,
  parameter int              TIMEOUT  = 1000000,
  parameter logic [NREG*8-1:0] REG_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_cmd_engine_if.slave      uart,
  input  logic [NHIST*32-1:0]     hist_data,
  output logic                    hist_reset,
  output logic [NREG*8-1:0]       cfg_regs,
  output logic                    cfg_update,
  output logic [7:0]              cfg_addr,
  output logic [7:0]              err_count,
  output logic [2:0]              dbg_state
);

  localparam int HBYTES = NHIST * 4;
  // Index must reach HBYTES (checksum slot after a full dump) without wrapping.
  localparam int IW = $clog2(HBYTES + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
  localparam logic [8:0]    NREG_W = 9'(NREG);
`ifdef CMD_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARGS    = 3'd1,
    S_EXEC    = 3'd2,
    S_TX_LOAD = 3'd3,
    S_TX_WAIT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          opc_q, opc_d;
  logic [7:0]          arg0_q, arg0_d;
  logic                argi_q, argi_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [NREG*8-1:0]   regs_q, regs_d;
  logic                upd_q, upd_d;
  logic [7:0]          caddr_q, caddr_d;
  logic [7:0]          err_q, err_d;
  logic                txs_q, txs_d;
  logic [7:0]          txd_q, txd_d;
  logic [NHIST*32-1:0] snap_q, snap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          resp_q, resp_d;
  logic                hist_q, hist_d;

  logic                err_inc;
  logic                wr_en;
  logic [7:0]          wr_val;
  logic                addr_ok;
  logic [7:0]          rd_byte;
  logic [7:0]          cur_byte;
  logic [IW-1:0]       pay_len;
  logic [IW-1:0]       last_idx;
  logic                hist_reset_c;

  always_comb begin
    // Address checks and register reads always refer to the stored first argument.
    addr_ok = ({1'b0, arg0_q} < NREG_W);
    rd_byte = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (arg0_q == 8'(i)) rd_byte = regs_q[i*8 +: 8];
    end

    // Response length: one byte unless dumping the histogram snapshot.
    pay_len  = hist_q ? IW'(HBYTES) : IW'(1);
    last_idx = pay_len - IW'(1) + IW'(CSUM_EN);
    if (CSUM_EN && (idx_q == pay_len)) cur_byte = csum_q;
    else if (hist_q)                   cur_byte = 8'(snap_q >> {idx_q, 3'b000});
    else                               cur_byte = resp_q;
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    arg0_d       = arg0_q;
    argi_d       = argi_q;
    tcnt_d       = tcnt_q;
    regs_d       = regs_q;
    upd_d        = 1'b0;
    caddr_d      = caddr_q;
    err_d        = err_q;
    txs_d        = 1'b0;
    txd_d        = txd_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    resp_d       = resp_q;
    hist_d       = hist_q;
    err_inc      = 1'b0;
    wr_en        = 1'b0;
    wr_val       = 8'h00;
    hist_reset_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (uart.rx_ready) begin
          opc_d  = uart.rx_data;
          argi_d = 1'b0;
          tcnt_d = '0;
          case (uart.rx_data)
            8'h01, 8'h02, 8'h03: state_d = S_ARGS;
            8'h0D: begin
              // Restore lands on the edge that samples the opcode so that
              // cfg_update appears in the very next cycle.
              regs_d  = REG_INIT;
              upd_d   = 1'b1;
              caddr_d = 8'hFF;
              state_d = S_EXEC;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end

      S_ARGS: begin
        if (uart.rx_ready) begin
          tcnt_d = '0;
          if (!argi_q) begin
            arg0_d = uart.rx_data;
            if (opc_q == 8'h02) state_d = S_EXEC;
            else                argi_d  = 1'b1;
          end else begin
            // Final argument: write/toggle commit on this edge.
            if (addr_ok) begin
              wr_en   = 1'b1;
              wr_val  = (opc_q == 8'h01) ? uart.rx_data : (rd_byte ^ uart.rx_data);
              upd_d   = 1'b1;
              caddr_d = arg0_q;
            end else begin
              err_inc = 1'b1;
            end
            state_d = S_EXEC;
          end
        end else if (tcnt_q == TMAX) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_EXEC: begin
        idx_d  = '0;
        csum_d = 8'h00;
        hist_d = 1'b0;
        case (opc_q)
          8'h00: begin
            resp_d  = 8'(VERSION);
            state_d = S_TX_LOAD;
          end
          8'h02: begin
            resp_d  = addr_ok ? rd_byte : 8'h00;
            err_inc = !addr_ok;
            state_d = S_TX_LOAD;
          end
          8'h0A: begin
            snap_d       = hist_data;
            hist_reset_c = 1'b1;
            hist_d       = 1'b1;
            state_d      = S_TX_LOAD;
          end
          8'h01, 8'h03, 8'h0D: state_d = S_IDLE;
          default: begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_TX_LOAD: begin
        if (!uart.tx_busy) begin
          txd_d   = cur_byte;
          txs_d   = 1'b1;
          csum_d  = csum_q ^ cur_byte;
          state_d = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // One dead cycle gives the UART time to raise tx_busy.
        if (idx_q == last_idx) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_TX_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NREG; i++) begin
      if (wr_en && (arg0_q == 8'(i))) regs_d[i*8 +: 8] = wr_val;
    end

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= 8'h00;
      arg0_q  <= 8'h00;
      argi_q  <= 1'b0;
      tcnt_q  <= '0;
      regs_q  <= REG_INIT;
      upd_q   <= 1'b0;
      caddr_q <= 8'h00;
      err_q   <= 8'h00;
      txs_q   <= 1'b0;
      txd_q   <= 8'h00;
      snap_q  <= '0;
      idx_q   <= '0;
      csum_q  <= 8'h00;
      resp_q  <= 8'h00;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      arg0_q  <= arg0_d;
      argi_q  <= argi_d;
      tcnt_q  <= tcnt_d;
      regs_q  <= regs_d;
      upd_q   <= upd_d;
      caddr_q <= caddr_d;
      err_q   <= err_d;
      txs_q   <= txs_d;
      txd_q   <= txd_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      resp_q  <= resp_d;
      hist_q  <= hist_d;
    end
  end

  assign uart.tx_start = txs_q;
  assign uart.tx_data  = txd_q;
  assign hist_reset    = hist_reset_c;
  assign cfg_regs      = regs_q;
  assign cfg_update    = upd_q;
  assign cfg_addr      = caddr_q;
  assign err_count     = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// tb_serial_cmd_engine
//   Randomized self-checking bench for serial_cmd_engine. A UART model
//   captures transmitted bytes and emulates tx_busy; a reference model of the
//   register file, error counter and expected response bytes is kept here.
module tb_serial_cmd_engine;
  localparam int NREG    = 8;
  localparam int NHIST   = 2;
  localparam int TIMEOUT = 40;
  localparam logic [NREG*8-1:0] REG_INIT = 64'h8877_6655_4433_2211;
`ifdef CMD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_cmd_engine_if u_if ();
  logic [NHIST*32-1:0] hist_data;
  logic                hist_reset;
  logic [NREG*8-1:0]   cfg_regs;
  logic                cfg_update;
  logic [7:0]          cfg_addr;
  logic [7:0]          err_count;
  logic [2:0]          dbg_state;

  serial_cmd_engine #(
    .VERSION (21),
    .NREG    (NREG),
    .NHIST   (NHIST),
    .TIMEOUT (TIMEOUT),
    .REG_INIT(REG_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart      (u_if.slave),
    .hist_data (hist_data),
    .hist_reset(hist_reset),
    .cfg_regs  (cfg_regs),
    .cfg_update(cfg_update),
    .cfg_addr  (cfg_addr),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] mdl_regs[NREG];
  int         mdl_err;
  logic [7:0] resp_csum;
  int         upd_cnt = 0;

  function automatic logic [NREG*8-1:0] mdl_vec();
    logic [NREG*8-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*8 +: 8] = mdl_regs[i];
    return v;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NREG; i++) mdl_regs[i] = REG_INIT[i*8 +: 8];
    mdl_err = 0;
  endtask

  task automatic mdl_err_inc();
    if (mdl_err < 255) mdl_err++;
  endtask

  task automatic resp_begin();
    resp_csum = 8'h00;
  endtask

  task automatic resp_byte(input logic [7:0] b);
    exp_q.push_back(b);
    resp_csum ^= b;
  endtask

  task automatic resp_end();
    if (CSUM) exp_q.push_back(resp_csum);
  endtask

  // ---------------- UART model: capture bytes, emulate tx_busy ----------------
  initial begin : uart_model
    int  busy_cnt;
    bit  busy_pend;
    logic busy_seen;
    u_if.tx_busy = 1'b0;
    busy_cnt     = 0;
    busy_pend    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busy_seen = u_if.tx_busy;
      if (!rst_n) begin
        u_if.tx_busy = 1'b0;
        busy_cnt     = 0;
        busy_pend    = 1'b0;
      end else begin
        if (busy_pend) begin
          u_if.tx_busy = 1'b1;
          busy_cnt     = $urandom_range(1, 5);
          busy_pend    = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) u_if.tx_busy = 1'b0;
        end
        if (u_if.tx_start === 1'b1) begin
          checks++;
          if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_while_busy tx_busy=%b required 0", busy_seen);
          end
          got_q.push_back(u_if.tx_data);
          busy_pend = 1'b1;
        end
        if (cfg_update === 1'b1) upd_cnt++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns with #1 after the edge that samples the byte.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_data  = b;
    u_if.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.rx_ready = 1'b0;
  endtask

  // Waits (bounded) until the expected number of bytes arrived, then lingers
  // a little so that any surplus byte is captured too.
  task automatic wait_resp(output bit timed_out);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    timed_out = (got_q.size() < exp_q.size());
    idle(12);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    u_if.rx_ready = 1'b0;
    u_if.rx_data  = 8'h00;
    hist_data     = '0;
    idle(3);
    checks++; if (cfg_regs !== REG_INIT) begin errors++; $display("FAIL reset_cfg_regs got %h want %h", cfg_regs, REG_INIT); end
    checks++; if (u_if.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", u_if.tx_start); end
    checks++; if (u_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", u_if.tx_data); end
    checks++; if (hist_reset !== 1'b0) begin errors++; $display("FAIL reset_hist_reset got %b want 0", hist_reset); end
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL reset_cfg_update got %b want 0", cfg_update); end
    checks++; if (cfg_addr !== 8'h00) begin errors++; $display("FAIL reset_cfg_addr got %h want 00", cfg_addr); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %h want 00", err_count); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    mdl_reset();
    idle(2);
  endtask

  task automatic test_version();
    bit to;
    got_q.delete(); exp_q.delete();
    resp_begin(); resp_byte(8'h15); resp_end();
    send_byte(8'h00);
    wait_resp(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL version_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL version_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_read();
    bit to;
    send_byte(8'h01); send_byte(8'h03); send_byte(8'hA5);
    mdl_regs[3] = 8'hA5;
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL write_update got %b want 1", cfg_update); end
    checks++; if (cfg_addr !== 8'h03) begin errors++; $display("FAIL write_addr got %h want 03", cfg_addr); end
    checks++; if (cfg_regs !== mdl_vec()) begin errors++; $display("FAIL write_regs got %h want %h", cfg_regs, mdl_vec()); end
    idle(2);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL write_update_pulse got %b want 0", cfg_update); end
    resp_begin(); resp_byte(8'hA5); resp_end();
    send_byte(8'h02); send_byte(8'h03);
    wait_resp(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL read_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    send_byte(8'h03); send_byte(8'h03); send_byte(8'h0F);
    mdl_regs[3] = mdl_regs[3] ^ 8'h0F;
    checks++; if (cfg_regs[31:24] !== 8'hAA) begin errors++; $display("FAIL toggle_reg3 got %h want aa", cfg_regs[31:24]); end
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL toggle_update got %b want 1", cfg_update); end
    idle(2);
  endtask

  task automatic test_random_regs();
    bit to;
    for (int n = 0; n < 40; n++) begin
      int         op;
      int         addr;
      logic [7:0] val;
      bit         ok;
      op   = $urandom_range(0, 2);
      addr = $urandom_range(0, NREG + 3);
      val  = 8'($urandom);
      ok   = (addr < NREG);
      got_q.delete(); exp_q.delete();
      if (op != 2) begin
        send_byte(op == 0 ? 8'h01 : 8'h03); send_byte(8'(addr)); send_byte(val);
        if (ok) mdl_regs[addr] = (op == 0) ? val : (mdl_regs[addr] ^ val);
        else    mdl_err_inc();
        checks++;
        if (cfg_update !== ok) begin errors++; $display("FAIL rnd_update op%0d addr%0d got %b want %b", op, addr, cfg_update, ok); end
        if (ok) begin
          checks++;
          if (cfg_addr !== 8'(addr)) begin errors++; $display("FAIL rnd_cfg_addr got %h want %h", cfg_addr, 8'(addr)); end
        end
        idle(3);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL rnd_write_noresp got %0d bytes want 0", got_q.size()); end
      end else begin
        resp_begin(); resp_byte(ok ? mdl_regs[addr] : 8'h00); resp_end();
        if (!ok) mdl_err_inc();
        send_byte(8'h02); send_byte(8'(addr));
        wait_resp(to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin
          errors++; $display("FAIL rnd_read_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_read addr%0d byte%0d got %h want %h", addr, i, got_q[i], exp_q[i]); end
        end
      end
      checks++; if (cfg_regs !== mdl_vec()) begin errors++; $display("FAIL rnd_regs got %h want %h", cfg_regs, mdl_vec()); end
      checks++; if (err_count !== 8'(mdl_err)) begin errors++; $display("FAIL rnd_err got %0d want %0d", err_count, mdl_err); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_hist();
    bit to;
    for (int r = 0; r < 3; r++) begin
      logic [31:0] words[NHIST];
      if (r == 0) begin
        words[0] = 32'h0403_0201;
        words[1] = 32'h0807_0605;
      end else begin
        for (int w = 0; w < NHIST; w++) words[w] = $urandom;
      end
      for (int w = 0; w < NHIST; w++) hist_data[w*32 +: 32] = words[w];
      got_q.delete(); exp_q.delete();
      resp_begin();
      for (int w = 0; w < NHIST; w++)
        for (int b = 0; b < 4; b++) resp_byte(8'(words[w] >> (8 * b)));
      resp_end();
      send_byte(8'h0A);
      checks++; if (hist_reset !== 1'b1) begin errors++; $display("FAIL hist_reset_pulse got %b want 1", hist_reset); end
      idle(1);
      checks++; if (hist_reset !== 1'b0) begin errors++; $display("FAIL hist_reset_len got %b want 0", hist_reset); end
      // Live histogram moves on; the dump must come from the snapshot.
      hist_data = {$urandom, $urandom};
      if (r == 2) begin
        idle(3);
        send_byte(8'h7E);
      end
      wait_resp(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL hist_len round%0d got %0d want %0d", r, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL hist_byte round%0d idx%0d got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      checks++; if (err_count !== 8'(mdl_err)) begin errors++; $display("FAIL hist_err got %0d want %0d", err_count, mdl_err); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_restore();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h33);
    mdl_regs[2] = 8'h33;
    idle(2);
    send_byte(8'h0D);
    mdl_reset_regs_only();
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL restore_update got %b want 1", cfg_update); end
    checks++; if (cfg_addr !== 8'hFF) begin errors++; $display("FAIL restore_addr got %h want ff", cfg_addr); end
    checks++; if (cfg_regs !== REG_INIT) begin errors++; $display("FAIL restore_regs got %h want %h", cfg_regs, REG_INIT); end
    idle(3);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL restore_noresp got %0d bytes want 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic mdl_reset_regs_only();
    for (int i = 0; i < NREG; i++) mdl_regs[i] = REG_INIT[i*8 +: 8];
  endtask

  task automatic test_timeout();
    int u0;
    u0 = upd_cnt;
    send_byte(8'h01); send_byte(8'h05);
    idle(TIMEOUT + 5);
    mdl_err_inc();
    checks++; if (err_count !== 8'(mdl_err)) begin errors++; $display("FAIL timeout_err got %0d want %0d", err_count, mdl_err); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL timeout_state got %0d want 0", dbg_state); end
    checks++; if (upd_cnt != u0) begin errors++; $display("FAIL timeout_update got %0d pulses want 0", upd_cnt - u0); end
    checks++; if (cfg_regs !== mdl_vec()) begin errors++; $display("FAIL timeout_regs got %h want %h", cfg_regs, mdl_vec()); end
    send_byte(8'h7E);
    idle(3);
    mdl_err_inc();
    checks++; if (err_count !== 8'(mdl_err)) begin errors++; $display("FAIL unknown_err got %0d want %0d", err_count, mdl_err); end
    // Slow but in-time arguments still complete the write.
    send_byte(8'h01);
    idle(TIMEOUT - 10);
    send_byte(8'h04);
    idle(TIMEOUT - 10);
    send_byte(8'h5A);
    mdl_regs[4] = 8'h5A;
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL slow_update got %b want 1", cfg_update); end
    checks++; if (cfg_regs !== mdl_vec()) begin errors++; $display("FAIL slow_regs got %h want %h", cfg_regs, mdl_vec()); end
    idle(2);
  endtask

  task automatic test_err_saturate();
    for (int n = 0; n < 260; n++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if (op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0D}) op = 8'hFE;
      send_byte(op);
      mdl_err_inc();
      idle(1);
    end
    idle(2);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got %0d want 255", err_count); end
    checks++; if (err_count !== 8'(mdl_err)) begin errors++; $display("FAIL err_model got %0d want %0d", err_count, mdl_err); end
  endtask

  task automatic test_reset_mid_dump();
    bit to;
    int t;
    int bad;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'hC3);
    idle(2);
    got_q.delete(); exp_q.delete();
    hist_data = {$urandom, $urandom};
    send_byte(8'h0A);
    t = 0;
    while (got_q.size() < 1 && t < 200) begin idle(1); t++; end
    checks++; if (got_q.size() < 1) begin errors++; $display("FAIL middump_start got %0d bytes want >=1", got_q.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (u_if.tx_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL middump_tx_start got %0d pulses want 0", bad); end
    checks++; if (cfg_regs !== REG_INIT) begin errors++; $display("FAIL middump_regs got %h want %h", cfg_regs, REG_INIT); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL middump_err got %0d want 0", err_count); end
    rst_n = 1'b1;
    mdl_reset();
    got_q.delete(); exp_q.delete();
    idle(30);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL middump_resume got %0d bytes want 0", got_q.size()); end
    got_q.delete();
    resp_begin(); resp_byte(8'h15); resp_end();
    send_byte(8'h00);
    wait_resp(to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL post_reset_len got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_reset_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_version();
    test_write_read();
    test_random_regs();
    test_hist();
    test_restore();
    test_timeout();
    test_err_saturate();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
